// File: rtl/fetch_controller.sv
// rtl/fetch_controller.sv - instruction fetch controller with redirect, halt and handshake count
// A single registered output slot; the pc is the address of the next instruction to load into it.

module fetch_controller #(
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned START_PC   = 0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic                  halt_req,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_target,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic [7:0]            imem_instr,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    output logic [7:0]            instr_data,
    output logic [ADDR_WIDTH-1:0] instr_pc,
    output logic                  busy,
    output logic [15:0]           fetch_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic                  valid_q, valid_d;
    logic [7:0]            data_q, data_d;
    logic [ADDR_WIDTH-1:0] ipc_q, ipc_d;
    logic [15:0]           cnt_q, cnt_d;
    logic                  handshake;

    assign handshake = valid_q && instr_ready;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        valid_d = valid_q;
        data_d  = data_q;
        ipc_d   = ipc_q;
        cnt_d   = cnt_q;

        // A handshake counts even when a redirect or halt discards the slot in the same cycle.
        if (handshake && (cnt_q != 16'hFFFF)) begin
            cnt_d = cnt_q + 16'd1;
        end

        case (state_q)
            IDLE: begin
                valid_d = 1'b0;
                if (start) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (halt_req) begin
                    state_d = HALT;
                    valid_d = 1'b0;
                    if (redirect_valid) begin
                        pc_d = redirect_target;
                    end
                end else if (redirect_valid) begin
                    pc_d    = redirect_target;
                    valid_d = 1'b0;
                end else if (!valid_q || instr_ready) begin
                    data_d  = imem_instr;
                    ipc_d   = pc_q;
                    valid_d = 1'b1;
                    pc_d    = pc_q + 1'b1;
                end
            end
            HALT: begin
                valid_d = 1'b0;
                if (redirect_valid) begin
                    pc_d = redirect_target;
                end
                if (start && !halt_req) begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            pc_q    <= ADDR_WIDTH'(START_PC);
            valid_q <= 1'b0;
            data_q  <= 8'h00;
            ipc_q   <= '0;
            cnt_q   <= 16'h0000;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            ipc_q   <= ipc_d;
            cnt_q   <= cnt_d;
        end
    end

    assign imem_addr   = pc_q;
    assign instr_valid = valid_q;
    assign instr_data  = data_q;
    assign instr_pc    = ipc_q;
    assign busy        = (state_q == RUN);
    assign fetch_cnt   = cnt_q;

endmodule
